// File: rtl/mult_operand_feeder_if.sv
// Operand, result and multiplier-handshake bus of the operand feeder.
// The slave modport is the feeder; the master modport is the producer/multiplier side.
interface mult_operand_feeder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  iPush;
  logic [DATA_WIDTH-1:0] iData_A;
  logic [DATA_WIDTH-1:0] iData_B;
  logic                  oFull;
  logic [CNT_W-1:0]      oCount;
  logic                  oOverflow;
  logic [DATA_WIDTH-1:0] oMult_A;
  logic [DATA_WIDTH-1:0] oMult_B;
  logic                  oValid_Data;
  logic                  oAcknoledged;
  logic                  iMult_Idle;
  logic                  iMult_Done;
  logic [DATA_WIDTH-1:0] iMult_Result;
  logic [DATA_WIDTH-1:0] oResult;
  logic                  oResult_Valid;
  logic                  oTimeout;

  modport slave (
    input  iPush, iData_A, iData_B, iMult_Idle, iMult_Done, iMult_Result,
    output oFull, oCount, oOverflow, oMult_A, oMult_B, oValid_Data,
           oAcknoledged, oResult, oResult_Valid, oTimeout
  );

  modport master (
    output iPush, iData_A, iData_B, iMult_Idle, iMult_Done, iMult_Result,
    input  oFull, oCount, oOverflow, oMult_A, oMult_B, oValid_Data,
           oAcknoledged, oResult, oResult_Valid, oTimeout
  );
endinterface

// File: rtl/mult_operand_feeder.sv
// Operand FIFO in front of the multiplier: launches one pair at a time over the
// valid/done/acknowledge handshake and pulses each product out. Optional watchdog: FEEDER_WATCHDOG_EN.
module mult_operand_feeder #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 4,
  parameter int VALID_CYCLES = 10
`ifdef FEEDER_WATCHDOG_EN
  ,
  parameter int TIMEOUT      = 256
`endif
) (
  input  logic                 Clock,
  input  logic                 Reset,
  mult_operand_feeder_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int VC_W  = $clog2(VALID_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [VC_W-1:0]  VC_LAST = VC_W'(VALID_CYCLES);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_D, ACK} state_t;

  state_t                  state, state_d;
  logic [2*DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    full, push_ok, pop, overflow;
  logic [VC_W-1:0]         vcnt, vcnt_d;
  logic                    valid_q, valid_d;
  logic                    ack_q, ack_d;
  logic                    rv_q, rv_d;
  logic                    capture, wd_expire;
  logic [DATA_WIDTH-1:0]   mult_a, mult_b, result;

  // A push is judged against the occupancy before this edge, so a same-cycle pop never rescues it.
  assign full    = (count == DEPTH_C);
  assign push_ok = bus.iPush && !full;

  always_ff @(posedge Clock) begin
    if (push_ok) mem[wr_ptr] <= {bus.iData_A, bus.iData_B};
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (bus.iPush && full) overflow <= 1'b1;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

`ifdef FEEDER_WATCHDOG_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] wcnt;
  logic            timeout_q;

  assign wd_expire = (state == WAIT_D) && !bus.iMult_Done && (wcnt == TO_LAST);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wcnt      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wcnt <= (state == WAIT_D) ? wcnt + 1'b1 : '0;
      if (wd_expire) timeout_q <= 1'b1;
    end
  end

  assign bus.oTimeout = timeout_q;
`else
  assign wd_expire    = 1'b0;
  assign bus.oTimeout = 1'b0;
`endif

  always_comb begin
    state_d = state;
    vcnt_d  = vcnt;
    valid_d = valid_q;
    ack_d   = ack_q;
    rv_d    = 1'b0;
    capture = 1'b0;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if ((count != '0) && bus.iMult_Idle) begin
          pop     = 1'b1;
          vcnt_d  = '0;
          state_d = LAUNCH;
        end
      end
      // Valid rises one edge after the pop and stays high for exactly VALID_CYCLES cycles.
      LAUNCH: begin
        if (vcnt == VC_LAST) begin
          valid_d = 1'b0;
          state_d = WAIT_D;
        end else begin
          valid_d = 1'b1;
          vcnt_d  = vcnt + 1'b1;
        end
      end
      WAIT_D: begin
        if (bus.iMult_Done) begin
          capture = 1'b1;
          rv_d    = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK;
        end else if (wd_expire) begin
          state_d = IDLE;
        end
      end
      ACK: begin
        if (!bus.iMult_Done) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      vcnt    <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state   <= state_d;
      vcnt    <= vcnt_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      rv_q    <= rv_d;
    end
  end

  // Operands hold from the pop until the next pop; the product holds until the next capture.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mult_a <= '0;
      mult_b <= '0;
      result <= '0;
    end else begin
      if (pop) {mult_a, mult_b} <= mem[rd_ptr];
      if (capture) result <= bus.iMult_Result;
    end
  end

  assign bus.oFull         = full;
  assign bus.oCount        = count;
  assign bus.oOverflow     = overflow;
  assign bus.oMult_A       = mult_a;
  assign bus.oMult_B       = mult_b;
  assign bus.oValid_Data   = valid_q;
  assign bus.oAcknoledged  = ack_q;
  assign bus.oResult       = result;
  assign bus.oResult_Valid = rv_q;
endmodule
